// File: rtl/data_mem_responder.sv
// Load/store responder backed by a word-organised RAM with byte/half/word lanes and error checks.
// Latency: rsp_valid rises LATENCY cycles after the accept cycle; one request outstanding at a time.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready is seen.
module data_mem_responder #(
   parameter logic [31:0] MEM_BASE = 32'h8000_0000,
   parameter int          DEPTH    = 4096,
   parameter int          LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int IDX_W      = $clog2(DEPTH);
   localparam int CNT_INIT_I = (LATENCY >= 2) ? LATENCY - 2 : 0;
   localparam logic [3:0] CNT_INIT = 4'(CNT_INIT_I);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
   } req_t;

   state_t            state;
   logic [3:0]        cnt;
   req_t              req_q;
   req_t              cur;
   logic              fire;
   logic              enter_resp;
   logic              in_range;
   logic              align_err;
   logic              err;
   logic [32:0]       addr_x;
   logic [32:0]       lo;
   logic [32:0]       hi;
   logic [31:0]       offs;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        strb;
   logic [31:0]       wword;
   logic [31:0]       rword;
   logic [15:0]       sh;
   logic [31:0]       ldata;
   logic [31:0]       mem [DEPTH];

   assign req_ready = (state == IDLE);
   assign fire      = req_valid && req_ready;

   // With LATENCY==1 the commit edge is the accept edge, so decode straight from the ports.
   always_comb begin
      cur = req_q;
      if (state == IDLE) begin
         cur = {req_wen, req_addr, req_wdata, req_size, req_unsigned};
      end
   end

   always_comb begin
      enter_resp = 1'b0;
      if (state == IDLE && fire && LATENCY == 1) begin
         enter_resp = 1'b1;
      end else if (state == WAIT && cnt == 4'd0) begin
         enter_resp = 1'b1;
      end
   end

   always_comb begin
      lo       = {1'b0, MEM_BASE};
      hi       = lo + 33'(4 * DEPTH);
      addr_x   = {1'b0, cur.addr};
      in_range = (addr_x >= lo) && (addr_x < hi);
      offs     = cur.addr - MEM_BASE;
      idx      = IDX_W'(offs >> 2);
      case (cur.size)
         2'd0:    align_err = 1'b0;
         2'd1:    align_err = cur.addr[0];
         2'd2:    align_err = |cur.addr[1:0];
         default: align_err = 1'b1;
      endcase
      err = !in_range || align_err;
   end

   always_comb begin
      case (cur.size)
         2'd0: begin
            strb  = 4'b0001 << cur.addr[1:0];
            wword = {4{cur.wdata[7:0]}};
         end
         2'd1: begin
            strb  = cur.addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{cur.wdata[15:0]}};
         end
         default: begin
            strb  = 4'b1111;
            wword = cur.wdata;
         end
      endcase
   end

   always_comb begin
      rword = mem[idx];
      sh    = 16'(rword >> {cur.addr[1:0], 3'b000});
      case (cur.size)
         2'd0:    ldata = cur.uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'd1:    ldata = cur.uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: ldata = rword;
      endcase
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (rst_n && enter_resp && cur.wen && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
               mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         if (fire) begin
            req_q <= cur;
         end
         if (enter_resp) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || cur.wen) ? 32'd0 : ldata;
         end else begin
            case (state)
               IDLE: begin
                  if (fire) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
               WAIT: cnt <= cnt - 4'd1;
               RESP: begin
                  if (rsp_ready) begin
                     state     <= IDLE;
                     rsp_valid <= 1'b0;
                     rsp_rdata <= 32'd0;
                     rsp_err   <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
